neuron_output_collector: RTL and testbench

//  Collects per-neuron outputs of the final layer. Each neuron has its own valid and may finish on a different cycle.

---
 rtl/neuron_output_collector_pkg.sv | 30 +++
 rtl/neuron_output_collector_if.sv | 23 ++
 rtl/neuron_output_collector_holdoff_timer.sv | 28 ++
 rtl/neuron_output_collector.sv | 110 +++++++++++
 tb/tb_neuron_output_collector.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/neuron_output_collector_pkg.sv
// Shared constants, types and the lane-merge helper for the final-layer output collector.
package neuron_output_collector_pkg;

   localparam int NUM_NEURON  = 10;
   localparam int DATA_WIDTH  = 16;
   localparam int HOLD_OFF    = NUM_NEURON + 1;
   localparam int FRAME_WIDTH = NUM_NEURON * DATA_WIDTH;
   localparam int COUNT_WIDTH = $clog2(HOLD_OFF + 1);

   typedef enum logic {
      COLLECT = 1'b0,
      PENDING = 1'b1
   } state_t;

   typedef logic [FRAME_WIDTH-1:0] frame_t;
   typedef logic [NUM_NEURON-1:0]  mask_t;

   // Replace every lane whose select bit is set with the incoming lane.
   function automatic frame_t merge_lanes(frame_t held, frame_t incoming, mask_t sel);
      frame_t result;
      result = held;
      for (int k = 0; k < NUM_NEURON; k++) begin
         if (sel[k]) begin
            result[k*DATA_WIDTH +: DATA_WIDTH] = incoming[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/neuron_output_collector_if.sv
// Neuron-output bus: per-lane valids and data in, packed frame and status out.
interface neuron_output_collector_if
   import neuron_output_collector_pkg::*;
   ();

   frame_t i_data;
   mask_t  i_valid;
   frame_t o_data;
   logic   o_data_valid;
   logic   o_busy;
   logic   o_overrun;

   modport master (
      output i_data, i_valid,
      input  o_data, o_data_valid, o_busy, o_overrun
   );

   modport slave (
      input  i_data, i_valid,
      output o_data, o_data_valid, o_busy, o_overrun
   );

endinterface

// File: rtl/neuron_output_collector_holdoff_timer.sv
// Down-counter enforcing the minimum spacing between emitted frames.
module neuron_output_collector_holdoff_timer
   import neuron_output_collector_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic zero,
   output logic expiring
);

   logic [COUNT_WIDTH-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= COUNT_WIDTH'(HOLD_OFF);
      end else if (count != '0) begin
         count <= count - COUNT_WIDTH'(1);
      end
   end

   // expiring: the counter is at zero now or reaches zero on this edge.
   assign zero     = (count == '0);
   assign expiring = (count <= COUNT_WIDTH'(1));

endmodule

// File: rtl/neuron_output_collector.sv
// Gathers per-neuron outputs into one frame and emits it as a single-cycle pulse,
// spacing frames so the downstream arg-max scan is never restarted mid-operation.
module neuron_output_collector
   import neuron_output_collector_pkg::*;
(
   input  logic                      i_clk,
   input  logic                      reset_n,
   neuron_output_collector_if.slave  bus
);

   state_t state, state_next;
   mask_t  mask;
   frame_t buffer;
   frame_t merged;
   frame_t data_q;
   logic   data_valid_q;
   logic   overrun_q;
   logic   timer_zero;
   logic   timer_expiring;
   logic   capture;
   logic   clear_mask;
   logic   emit;
   logic   emit_merged;
   logic   overrun_set;

   assign merged = merge_lanes(buffer, bus.i_data, bus.i_valid);

   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= COLLECT;
      end else begin
         state <= state_next;
      end
   end

   // A frame blocked by the holdoff waits in PENDING; the exit edge behaves like COLLECT for new lanes.
   always_comb begin
      state_next  = state;
      capture     = 1'b0;
      clear_mask  = 1'b0;
      emit        = 1'b0;
      emit_merged = 1'b0;
      overrun_set = 1'b0;
      case (state)
         COLLECT: begin
            capture     = 1'b1;
            overrun_set = |(mask & bus.i_valid);
            if (&(mask | bus.i_valid)) begin
               clear_mask = 1'b1;
               if (timer_zero) begin
                  emit        = 1'b1;
                  emit_merged = 1'b1;
               end else begin
                  state_next = PENDING;
               end
            end
         end
         PENDING: begin
            overrun_set = |bus.i_valid;
            if (timer_expiring) begin
               emit        = 1'b1;
               capture     = 1'b1;
               overrun_set = 1'b0;
               state_next  = COLLECT;
            end
         end
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         mask         <= '0;
         buffer       <= '0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         data_valid_q <= emit;
         if (emit) begin
            data_q <= emit_merged ? merged : buffer;
         end
         if (capture) begin
            buffer <= merged;
         end
         if (clear_mask) begin
            mask <= '0;
         end else if (capture) begin
            mask <= mask | bus.i_valid;
         end
         if (overrun_set) begin
            overrun_q <= 1'b1;
         end
      end
   end

   neuron_output_collector_holdoff_timer u_holdoff_timer (
      .clk      (i_clk),
      .rst_n    (reset_n),
      .load     (emit),
      .zero     (timer_zero),
      .expiring (timer_expiring)
   );

   assign bus.o_data       = data_q;
   assign bus.o_data_valid = data_valid_q;
   assign bus.o_busy       = (state == PENDING) || !timer_zero;
   assign bus.o_overrun    = overrun_q;

endmodule

// File: tb/tb_neuron_output_collector.sv
// Self-checking bench: table of per-cycle vectors plus hand-written holdoff/reset/stall sequences.
module tb_neuron_output_collector;
   import neuron_output_collector_pkg::*;

   localparam int W = FRAME_WIDTH;

   typedef struct {
      logic   wait_idle;
      mask_t  valid;
      frame_t data;
      logic   expect_frame;
      frame_t frame;
      logic   exp_valid;
      logic   exp_overrun;
   } vec_t;

   logic   i_clk = 1'b0;
   logic   reset_n;
   int     tests_run = 0;
   int     tests_failed = 0;
   int     cycle = 0;
   int     pulses = 0;
   int     pulse_cycle[$];
   frame_t sb[$];
   vec_t   vecs[$];

   neuron_output_collector_if bus();

   neuron_output_collector dut (
      .i_clk   (i_clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cycle <= cycle + 1;

   task automatic check_output(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Every emitted frame must match the oldest scoreboard entry.
   always @(negedge i_clk) begin
      if (bus.o_data_valid === 1'b1) begin
         pulses++;
         pulse_cycle.push_back(cycle);
         if (sb.size() == 0) begin
            check_output("unexpected_pulse", W'(1), W'(0));
         end else begin
            check_output("frame_data", bus.o_data, sb.pop_front());
         end
      end
   end

   function automatic frame_t lane_frame(input int base);
      frame_t f;
      for (int k = 0; k < NUM_NEURON; k++) f[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(base + k);
      return f;
   endfunction

   function automatic frame_t set_lane(input frame_t f, input int k, input logic [DATA_WIDTH-1:0] val);
      frame_t r;
      r = f;
      r[k*DATA_WIDTH +: DATA_WIDTH] = val;
      return r;
   endfunction

   function automatic vec_t make_vec(input logic wi, input mask_t v, input frame_t d,
                                     input logic ef, input frame_t f, input logic ev, input logic eo);
      vec_t r;
      r.wait_idle = wi; r.valid = v; r.data = d; r.expect_frame = ef;
      r.frame = f; r.exp_valid = ev; r.exp_overrun = eo;
      return r;
   endfunction

   // One clock edge with the given valids; returns just after the following falling edge.
   task automatic apply_stimulus(input mask_t valid, input frame_t data);
      bus.i_valid = valid;
      bus.i_data  = data;
      @(posedge i_clk);
      #1;
      bus.i_valid = '0;
      @(negedge i_clk);
      #1;
   endtask

   task automatic wait_not_busy();
      int n = 0;
      while (bus.o_busy && n < 40) begin
         apply_stimulus('0, '0);
         n++;
      end
      check_output("busy_timeout", W'(bus.o_busy), W'(0));
   endtask

   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      apply_stimulus('0, '0);
      apply_stimulus('0, '0);
      check_output({tag, "_o_data"},    bus.o_data, '0);
      check_output({tag, "_valid"},     W'(bus.o_data_valid), W'(0));
      check_output({tag, "_busy"},      W'(bus.o_busy), W'(0));
      check_output({tag, "_overrun"},   W'(bus.o_overrun), W'(0));
      @(posedge i_clk);
      #1;
      reset_n = 1'b1;
      @(negedge i_clk);
      #1;
   endtask

   initial begin
      frame_t junk;
      frame_t d;
      frame_t fa;
      frame_t fb;
      frame_t fresh;
      frame_t exp3;
      int     n;
      int     busy_drops;
      int     gap;
      int     bad;

      junk = {NUM_NEURON{16'hDEAD}};
      reset_n     = 1'b0;
      bus.i_valid = '0;
      bus.i_data  = '0;

      // All lanes at once, then one lane per cycle from 9 down to 0, then a double write on lane 3.
      vecs.push_back(make_vec(1'b0, '1, lane_frame(1), 1'b1, lane_frame(1), 1'b1, 1'b0));
      for (int k = NUM_NEURON - 1; k >= 0; k--) begin
         d = set_lane(junk, k, DATA_WIDTH'(16'h00A0 + k));
         vecs.push_back(make_vec(k == NUM_NEURON - 1, mask_t'(1) << k, d,
                                 k == 0, lane_frame(16'h00A0), k == 0, 1'b0));
      end
      exp3 = set_lane(lane_frame(16'h0300), 3, 16'd7);
      vecs.push_back(make_vec(1'b1, mask_t'(1) << 3, set_lane(junk, 3, 16'd5), 1'b0, '0, 1'b0, 1'b0));
      vecs.push_back(make_vec(1'b0, mask_t'(1) << 3, set_lane(junk, 3, 16'd7), 1'b0, '0, 1'b0, 1'b1));
      vecs.push_back(make_vec(1'b0, ~(mask_t'(1) << 3), set_lane(lane_frame(16'h0300), 3, 16'hDEAD),
                              1'b1, exp3, 1'b1, 1'b1));

      do_reset("por");

      foreach (vecs[i]) begin
         if (vecs[i].wait_idle) wait_not_busy();
         if (vecs[i].expect_frame) sb.push_back(vecs[i].frame);
         apply_stimulus(vecs[i].valid, vecs[i].data);
         check_output($sformatf("vec%0d_valid", i), W'(bus.o_data_valid), W'(vecs[i].exp_valid));
         check_output($sformatf("vec%0d_overrun", i), W'(bus.o_overrun), W'(vecs[i].exp_overrun));
      end
      apply_stimulus('0, '0);
      check_output("overrun_sticky", W'(bus.o_overrun), W'(1));
      check_output("pulse_one_cycle", W'(bus.o_data_valid), W'(0));

      // Back-to-back frames: second one waits out the holdoff in PENDING.
      do_reset("rst_t4");
      fa = lane_frame(16'h1000);
      fb = lane_frame(16'h2000);
      sb.push_back(fa);
      apply_stimulus('1, fa);
      check_output("t4_first_valid", W'(bus.o_data_valid), W'(1));
      check_output("t4_first_overrun", W'(bus.o_overrun), W'(0));
      sb.push_back(fb);
      apply_stimulus('1, fb);
      check_output("t4_pending_valid", W'(bus.o_data_valid), W'(0));
      check_output("t4_pending_busy", W'(bus.o_busy), W'(1));
      check_output("t4_pending_overrun0", W'(bus.o_overrun), W'(0));
      apply_stimulus(mask_t'(1), {NUM_NEURON{16'hFFFF}});
      check_output("t4_drop_overrun", W'(bus.o_overrun), W'(1));
      n = 0;
      busy_drops = 0;
      while (!bus.o_data_valid && n < 20) begin
         if (!bus.o_busy) busy_drops++;
         apply_stimulus('0, '0);
         n++;
      end
      check_output("t4_second_pulse", W'(bus.o_data_valid), W'(1));
      check_output("t4_busy_between", W'(busy_drops), W'(0));
      gap = (pulse_cycle.size() >= 2) ?
            pulse_cycle[pulse_cycle.size()-1] - pulse_cycle[pulse_cycle.size()-2] : -1;
      check_output("t4_pulse_gap", W'(gap), W'(HOLD_OFF));
      apply_stimulus('0, '0);
      check_output("t4_pulse_one_cycle", W'(bus.o_data_valid), W'(0));

      // Reset with half a frame captured; only the fresh frame may come out.
      wait_not_busy();
      apply_stimulus(mask_t'(10'h01F), lane_frame(16'h5500));
      check_output("t5_partial_valid", W'(bus.o_data_valid), W'(0));
      do_reset("rst_t5");
      fresh = lane_frame(16'h6600);
      apply_stimulus(mask_t'(10'h3E0), fresh);
      check_output("t5_half_valid", W'(bus.o_data_valid), W'(0));
      sb.push_back(fresh);
      apply_stimulus(mask_t'(10'h01F), fresh);
      check_output("t5_fresh_valid", W'(bus.o_data_valid), W'(1));
      check_output("t5_fresh_overrun", W'(bus.o_overrun), W'(0));

      // Lane 9 never arrives: nothing is emitted and the block stays idle.
      wait_not_busy();
      apply_stimulus(mask_t'(10'h0FF), lane_frame(16'h7700));
      apply_stimulus(mask_t'(10'h100), lane_frame(16'h7700));
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         if (bus.o_data_valid || bus.o_busy) bad++;
         apply_stimulus('0, '0);
      end
      check_output("t6_stall_quiet", W'(bad), W'(0));

      check_output("sb_empty", W'(sb.size()), W'(0));
      check_output("pulse_total", W'(pulses), W'(6));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
